// File: rtl/alu_unit.sv
// alu_unit: registered 16-bit ALU (ADD/SUB/AND single-cycle, MUL shift-add over MUL_CYCLES edges); ports clk, rst (async high), inputdata {op,A,B}, Y, cout, overflow
module alu_unit #(
  parameter int WIDTH = 16,
  parameter int MUL_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2*WIDTH+1:0]   inputdata,
  output logic [WIDTH-1:0]     Y,
  output logic                 cout,
  output logic                 overflow
);
  localparam int CW = $clog2(MUL_CYCLES);
  typedef enum logic {IDLE, MUL_RUN} state_t;
  state_t state, state_n;
  logic [1:0] op;
  logic [WIDTH-1:0] a, b, y_n, mplier, mplier_n;
  logic [WIDTH:0] sum, dif;
  logic [2*WIDTH-1:0] mcand, mcand_n, acc, acc_n, acc_add;
  logic [CW-1:0] cnt, cnt_n;
  logic cout_n, ovf_n;
  assign {op, a, b} = inputdata;
  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};
  assign acc_add = mplier[0] ? acc + mcand : acc;
  always_comb begin
    state_n = state;
    y_n = Y;
    cout_n = cout;
    ovf_n = overflow;
    mcand_n = mcand;
    mplier_n = mplier;
    acc_n = acc;
    cnt_n = cnt;
    if (state == IDLE) begin
      if (op == 2'b00) begin
        y_n = sum[WIDTH-1:0];
        cout_n = sum[WIDTH];
        ovf_n = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end else if (op == 2'b01) begin
        y_n = dif[WIDTH-1:0];
        cout_n = ~dif[WIDTH];
        ovf_n = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
      end else if (op == 2'b10) begin
        mcand_n = {{WIDTH{1'b0}}, a};
        mplier_n = b;
        acc_n = '0;
        cnt_n = '0;
        state_n = MUL_RUN;
      end else begin
        y_n = a & b;
        cout_n = 1'b0;
        ovf_n = 1'b0;
      end
    end else begin
      acc_n = acc_add;
      mcand_n = mcand << 1;
      mplier_n = mplier >> 1;
      cnt_n = cnt + 1'b1;
      if (cnt == CW'(MUL_CYCLES - 1)) begin
        y_n = acc_add[WIDTH-1:0];
        cout_n = 1'b0;
        ovf_n = |acc_add[2*WIDTH-1:WIDTH];
        state_n = IDLE;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      Y <= '0;
      cout <= 1'b0;
      overflow <= 1'b0;
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      Y <= y_n;
      cout <= cout_n;
      overflow <= ovf_n;
      mcand <= mcand_n;
      mplier <= mplier_n;
      acc <= acc_n;
      cnt <= cnt_n;
    end
  end
endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed self-checking bench for alu_unit
module tb_alu_unit;
  logic clk = 1'b0;
  logic rst;
  logic [33:0] inputdata;
  logic [15:0] Y;
  logic cout, overflow;
  int n_checks = 0;
  int n_fail = 0;
  alu_unit dut (.clk(clk), .rst(rst), .inputdata(inputdata), .Y(Y), .cout(cout), .overflow(overflow));
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    inputdata = '0;
    cyc();
    cyc();
    n_checks++;
    if ({Y, cout, overflow} !== {16'h0000, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset Y=%h c=%b o=%b expected Y=0000 c=0 o=0", Y, cout, overflow);
    end
    rst = 1'b0;
  endtask
  task automatic single(input string name, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] ey, input logic ec, input logic eo);
    inputdata = {op, a, b};
    cyc();
    n_checks++;
    if ({Y, cout, overflow} !== {ey, ec, eo}) begin
      n_fail++;
      $display("FAIL %s Y=%h c=%b o=%b expected Y=%h c=%b o=%b", name, Y, cout, overflow, ey, ec, eo);
    end
  endtask
  task automatic test_add();
    single("add_7f7f", 2'b00, 16'h7F7F, 16'h0000, 16'h7F7F, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) begin
      cyc();
      n_checks++;
      if ({Y, cout, overflow} !== {16'h7F7F, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL add_stable[%0d] Y=%h c=%b o=%b expected Y=7f7f c=0 o=0", i, Y, cout, overflow);
      end
    end
    single("add_carry", 2'b00, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
    single("add_ovf", 2'b00, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
    single("add_both", 2'b00, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1, 1'b0);
  endtask
  task automatic test_sub();
    single("sub_borrow", 2'b01, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0);
    single("sub_ovf", 2'b01, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1);
    single("sub_equal", 2'b01, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0);
  endtask
  task automatic test_and();
    single("and", 2'b11, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0);
  endtask
  task automatic mul(input string name, input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] hy, input logic hc, input logic ho,
                     input logic [15:0] ey, input logic eo);
    inputdata = {2'b10, a, b};
    cyc();
    inputdata = {2'b00, 16'hFFFF, 16'hFFFF};
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if ({Y, cout, overflow} !== {hy, hc, ho}) begin
        n_fail++;
        $display("FAIL %s_hold[%0d] Y=%h c=%b o=%b expected Y=%h c=%b o=%b", name, i, Y, cout, overflow, hy, hc, ho);
      end
      if (i == 7) inputdata = {2'b11, 16'hAAAA, 16'h5555};
      cyc();
    end
    n_checks++;
    if ({Y, cout, overflow} !== {ey, 1'b0, eo}) begin
      n_fail++;
      $display("FAIL %s Y=%h c=%b o=%b expected Y=%h c=0 o=%b", name, Y, cout, overflow, ey, eo);
    end
  endtask
  task automatic test_mul();
    mul("mul_ff_3", 16'h00FF, 16'h0003, 16'h3030, 1'b0, 1'b0, 16'h02FD, 1'b0);
    mul("mul_ovf", 16'h0100, 16'h0100, 16'h02FD, 1'b0, 1'b0, 16'h0000, 1'b1);
    mul("mul_max", 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b1);
  endtask
  task automatic test_reset_mid_mul();
    single("pre_rst_add", 2'b00, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1, 1'b0);
    inputdata = {2'b10, 16'hFFFF, 16'hFFFF};
    cyc();
    for (int i = 0; i < 8; i++) cyc();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({Y, cout, overflow} !== {16'h0000, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_mid_mul Y=%h c=%b o=%b expected Y=0000 c=0 o=0", Y, cout, overflow);
    end
    rst = 1'b0;
    single("post_rst_add", 2'b00, 16'h1234, 16'h0001, 16'h1235, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      cyc();
      n_checks++;
      if ({Y, cout, overflow} !== {16'h1235, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL post_rst_stable[%0d] Y=%h c=%b o=%b expected Y=1235 c=0 o=0", i, Y, cout, overflow);
      end
    end
  endtask
  task automatic test_back_to_back();
    single("b2b_and", 2'b11, 16'hFFFF, 16'h00FF, 16'h00FF, 1'b0, 1'b0);
    single("b2b_sub", 2'b01, 16'h0005, 16'h0003, 16'h0002, 1'b1, 1'b0);
    single("b2b_add", 2'b00, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1);
  endtask
  initial begin
    test_reset();
    test_add();
    test_sub();
    test_and();
    test_mul();
    test_reset_mid_mul();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_unit.md
Name: alu_unit

Overview:
- Registered 16-bit arithmetic/logic unit.
- Takes one packed 34-bit operation word (opcode, operand A, operand B) and produces a 16-bit result plus carry and overflow flags.
- ADD, SUB and AND complete in one clock. MUL is a multi-cycle shift-add that holds the unit busy for 16 iterations.
- Sits as the datapath execution unit, fed directly by a control/decode stage.

Parameters:
- WIDTH, 16, operand/result width. inputdata width is 2*WIDTH+2. Only 16 is required to be supported.
- MUL_CYCLES, 16, shift-add iterations for MUL. Must equal WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- inputdata  input  34  [33:32] opcode, [31:16] operand A, [15:0] operand B
- Y  output  16  registered result
- cout  output  1  registered carry / not-borrow flag
- overflow  output  1  registered overflow flag

Behaviour:
- Reset (async, rst=1): Y=0x0000, cout=0, overflow=0, state=IDLE, MUL accumulator/counter cleared. Reset mid-MUL aborts the multiply; no result is ever presented.
- States: IDLE, MUL_RUN.
- In IDLE, inputdata is sampled on every rising edge. There is no valid strobe; an unchanged input simply recomputes the same result.
- Opcode 00 ADD: {cout,Y} = A + B (17-bit sum). overflow = signed overflow (A[15]==B[15] and Y[15]!=A[15]).
- Opcode 01 SUB: Y = A - B mod 2^16. cout = 1 when no borrow (A >= B unsigned). overflow = signed overflow (A[15]!=B[15] and Y[15]!=A[15]).
- Opcode 10 MUL: unsigned 16x16 multiply via shift-add.
  - Sample edge: latch A and B, clear the 32-bit accumulator, counter=0, go to MUL_RUN. Y/cout/overflow hold their previous values.
  - Each following edge processes one multiplier bit, LSB first. If the bit is set, add the shifted multiplicand.
  - On the 16th MUL_RUN edge: Y = product[15:0], cout=0, overflow = (product[31:16] != 0). Return to IDLE.
  - Result is visible 16 edges after the sample edge. The next sample is taken on the edge after that.
  - inputdata is ignored during MUL_RUN.
- Opcode 11 AND: Y = A & B, cout=0, overflow=0.
- Single-cycle ops: result appears on Y after the sampling edge (1-clock latency) and holds until the next update.
- Outputs change only on clock edges or reset. There are no combinational paths from inputdata to the outputs.
- No X propagation: all registers are reset; unused opcode space does not exist (2-bit opcode fully decoded).

Test Plan:
- Reset, then inputdata=34'h0_7F7F_0000 (ADD A=0x7F7F, B=0) -> after 1 edge Y=0x7F7F, cout=0, overflow=0. Values stay stable across the following 17 idle clocks.
- ADD 0xFFFF+0x0001 -> Y=0x0000, cout=1, overflow=0. ADD 0x7FFF+0x0001 -> Y=0x8000, cout=0, overflow=1.
- SUB 0x0000-0x0001 -> Y=0xFFFF, cout=0, overflow=0. SUB 0x8000-0x0001 -> Y=0x7FFF, cout=1, overflow=1.
- MUL 0x00FF*0x0003 -> Y holds its previous value for 15 edges, then Y=0x02FD, overflow=0, cout=0. MUL 0x0100*0x0100 -> Y=0x0000, overflow=1. Changing inputdata during MUL_RUN has no effect on the result.
- AND 0xF0F0 & 0x3C3C -> Y=0x3030, cout=0, overflow=0.
- Assert rst for 1 ns mid-MUL (8 edges in) -> outputs immediately 0. After release, no MUL result appears, and an ADD issued next completes normally after 1 edge.
